// File: rtl/ws2812_pkg.sv
// Shared types, FSM encodings and helper functions for the WS2812 matrix streamer.
package ws2812_pkg;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } rgb_t;

    localparam logic [2:0] ST_INIT_LATCH = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_FETCH      = 3'd2;
    localparam logic [2:0] ST_SHIFT      = 3'd3;
    localparam logic [2:0] ST_LATCH      = 3'd4;

    // Round-to-nearest conversion of a duration in ns to clk cycles.
    function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
        return int'((clk_hz * ns + 64'sd500_000_000) / 64'sd1_000_000_000);
    endfunction

    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] br);
        logic [16:0] prod;
        prod = {9'd0, ch} * ({9'd0, br} + 17'd1);
        return 8'(prod >> 8);
    endfunction

    function automatic rgb_t scale_rgb(input rgb_t px, input logic [7:0] br);
        rgb_t res;
        res.g = scale_ch(px.g, br);
        res.r = scale_ch(px.r, br);
        res.b = scale_ch(px.b, br);
        return res;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Serialises a 24-bit word MSB first into WS2812 high/low bit cells of fixed length.
module ws2812_bit_encoder #(
    parameter int T0H_CYC = 10,
    parameter int T1H_CYC = 20,
    parameter int BIT_CYC = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] word,
    output logic        led,
    output logic        prefetch,
    output logic        done
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYC);

    logic [23:0]   sh_q, sh_d;
    logic [4:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          led_q, led_d;
    logic          bit_end_s;

    // Bit-cell sequencing; prefetch fires in the cycle before bit 23 so the
    // registered address is out on the first cycle of bit 23.
    always_comb begin
        bit_end_s = active_q && (cnt_q == CNT_LAST);
        prefetch  = bit_end_s && (idx_q == 5'd22);
        done      = bit_end_s && (idx_q == 5'd23);
        sh_d      = sh_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        if (load) begin
            sh_d     = word;
            idx_d    = 5'd0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (done) begin
            idx_d    = 5'd0;
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (bit_end_s) begin
            sh_d  = {sh_q[22:0], 1'b0};
            idx_d = idx_q + 5'd1;
            cnt_d = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        led_d = active_d && (cnt_d < (sh_d[23] ? T1H_C : T0H_C));
    end

    // Encoder state and registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= 24'd0;
            idx_q    <= 5'd0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/ws2812_matrix_stream.sv
// Streams one ROWS x COLS frame to a WS2812 chain from a 1-cycle-latency pixel store.
// Define WS2812_BRIGHTNESS_EN to add the brightness port and the per-channel scaler.
module ws2812_matrix_stream
    import ws2812_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int CLK_HZ     = 25_000_000,
    parameter int T0H_NS     = 400,
    parameter int T1H_NS     = 800,
    parameter int BIT_NS     = 1250,
    parameter int LATCH_US   = 80,
    parameter int SERPENTINE = 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_valid,
    output logic          frame_ready,
    output logic [RW-1:0] pix_row,
    output logic [CW-1:0] pix_col,
    input  logic [23:0]   pix_rgb,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          led_data,
    output logic          busy,
    output logic          frame_done
);

    localparam int T0H_C   = ns_to_cycles(CLK_HZ, T0H_NS);
    localparam int T1H_C   = ns_to_cycles(CLK_HZ, T1H_NS);
    localparam int BIT_C   = ns_to_cycles(CLK_HZ, BIT_NS);
    localparam int LATCH_C = ns_to_cycles(CLK_HZ, LATCH_US * 32'sd1000);
    localparam int LW      = (LATCH_C > 1) ? $clog2(LATCH_C) : 1;

    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_C - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    if (!((T1H_C < BIT_C) && (T0H_C >= 1))) begin : g_timing_check
        $error("ws2812_matrix_stream: bit timing needs T0H >= 1 and T1H < BIT");
    end

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] latch_cnt_q, latch_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          enc_load_s;
    logic          enc_prefetch_s;
    logic          enc_done_s;
    logic [23:0]   enc_word_s;

    // Physical column for a logical position k on a row (serpentine reverses odd rows).
    function automatic logic [CW-1:0] col_of(input logic [RW-1:0] row, input logic [CW-1:0] k);
        if ((SERPENTINE != 0) && row[0]) begin
            return COL_LAST - k;
        end else begin
            return k;
        end
    endfunction

    // Frame sequencing, pixel address walk and latch timing.
    always_comb begin
        state_d     = state_q;
        latch_cnt_d = latch_cnt_q;
        row_d       = row_q;
        k_d         = k_q;
        last_d      = last_q;
        enc_load_s  = 1'b0;
        case (state_q)
            ST_INIT_LATCH, ST_LATCH: begin
                if (latch_cnt_q == LATCH_LAST) begin
                    state_d     = ST_IDLE;
                    latch_cnt_d = '0;
                end else begin
                    latch_cnt_d = latch_cnt_q + LW'(1);
                end
            end
            ST_IDLE: begin
                if (frame_valid) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                enc_load_s = 1'b1;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (enc_prefetch_s) begin
                    if ((row_q == ROW_LAST) && (k_q == COL_LAST)) begin
                        last_d = 1'b1;
                    end else if (k_q == COL_LAST) begin
                        k_d   = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end else if (enc_done_s) begin
                    // Address returns to pixel 0 so pix_rgb is ready well before the next FETCH.
                    if (last_q) begin
                        state_d = ST_LATCH;
                        row_d   = '0;
                        k_d     = '0;
                        last_d  = 1'b0;
                    end else begin
                        enc_load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d     = ST_INIT_LATCH;
                latch_cnt_d = '0;
            end
        endcase
        col_d   = col_of(row_d, k_d);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_LATCH) && (latch_cnt_d == LATCH_LAST);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT_LATCH;
            latch_cnt_q <= '0;
            row_q       <= '0;
            k_q         <= '0;
            col_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            latch_cnt_q <= latch_cnt_d;
            row_q       <= row_d;
            k_q         <= k_d;
            col_q       <= col_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

`ifdef WS2812_BRIGHTNESS_EN
    rgb_t cap_q, cap_d;

    if (BIT_C < 3) begin : g_scale_check
        $error("ws2812_matrix_stream: brightness scaler needs BIT >= 3 cycles");
    end

    // Scale every cycle; the capture point reads the value two cycles after the address.
    always_comb begin
        cap_d = scale_rgb(rgb_t'(pix_rgb), brightness);
    end

    // Scaled pixel pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign enc_word_s = cap_q;
`else
    assign enc_word_s = pix_rgb;
`endif

    ws2812_bit_encoder #(
        .T0H_CYC (T0H_C),
        .T1H_CYC (T1H_C),
        .BIT_CYC (BIT_C)
    ) u_enc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (enc_load_s),
        .word     (enc_word_s),
        .led      (led_data),
        .prefetch (enc_prefetch_s),
        .done     (enc_done_s)
    );

    assign pix_row     = row_q;
    assign pix_col     = col_q;
    assign busy        = busy_q;
    assign frame_ready = ready_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_ws2812_matrix_stream.sv
// Directed bench for a 2x2 serpentine ws2812_matrix_stream at default timing.
module tb_ws2812_matrix_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [0:0]  pix_row;
    logic [0:0]  pix_col;
    logic [23:0] pix_rgb = 24'd0;
    logic [7:0]  brightness = 8'd255;
    logic        led_data;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic [23:0] mem [4];

    typedef struct {
        logic [7:0]       br;
        logic [3:0][23:0] px;
        logic [3:0][23:0] exp;
    } vec_t;
    vec_t vq[$];

    // Emission order for serpentine 2x2: (0,0),(0,1),(1,1),(1,0).
    int exp_row [4] = '{0, 0, 1, 1};
    int exp_col [4] = '{0, 1, 1, 0};

    always #5 clk = ~clk;

    // Pixel store with one cycle of read latency.
    always @(posedge clk) pix_rgb <= mem[{pix_row, pix_col}];

    ws2812_matrix_stream #(
        .ROWS(2), .COLS(2), .CLK_HZ(25_000_000), .T0H_NS(400), .T1H_NS(800),
        .BIT_NS(1250), .LATCH_US(80), .SERPENTINE(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .pix_rgb     (pix_rgb),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .led_data    (led_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] br,
                           input logic [23:0] p0, input logic [23:0] p1,
                           input logic [23:0] p2, input logic [23:0] p3,
                           input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input logic [23:0] e3);
        vec_t v;
        v.br = br;
        v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        vq.push_back(v);
    endtask

    task automatic count_init(input string tag);
        int n;
        bit low_ok;
        n = 0;
        low_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (led_data) low_ok = 1'b0;
        end while (!frame_ready && n < 5000);
        check(tag, n, 2000);
        check({tag, "_led_low"}, low_ok, 1);
    endtask

    // Loads the store, raises frame_valid and measures cycles until led_data first rises.
    task automatic start_frame(input int vi, input bit hold, output int lat);
        for (int i = 0; i < 4; i++) mem[i] = vq[vi].px[i];
        brightness = vq[vi].br;
        repeat (3) @(posedge clk);
        @(negedge clk);
        frame_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) frame_valid = 1'b0;
        end while (!led_data && lat < 20);
    endtask

    // Entered on the first sample of bit 0; returns on the frame_done sample.
    task automatic capture_frame(input int vi, input int mode, output int h0, output int h1, output int h23);
        logic [23:0] word;
        int h, n, ready_hi;
        bit seen_low, shape_ok, low_ok;
        word = 24'd0; shape_ok = 1'b1; ready_hi = 0; h0 = 0; h1 = 0; h23 = 0;
        for (int b = 0; b < 96; b++) begin
            h = 0;
            seen_low = 1'b0;
            for (int c = 0; c < 31; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (mode == 1 && b == 40) frame_valid = (c == 0);
                if (mode == 2 && b == 1 && c == 0) frame_valid = 1'b0;
                if (c == 0 && (b % 24) == 0) begin
                    check("addr_row", pix_row, exp_row[b / 24]);
                    check("addr_col", pix_col, exp_col[b / 24]);
                end
                if (led_data) begin
                    if (seen_low) shape_ok = 1'b0;
                    h++;
                end else begin
                    seen_low = 1'b1;
                end
                if (frame_ready) ready_hi++;
            end
            if (b == 0) h0 = h;
            if (b == 1) h1 = h;
            if (b == 23) h23 = h;
            if (h == 20) word = {word[22:0], 1'b1};
            else if (h == 10) word = {word[22:0], 1'b0};
            else begin
                shape_ok = 1'b0;
                word = {word[22:0], 1'b0};
            end
            if ((b % 24) == 23) check("pixel_word", word, vq[vi].exp[b / 24]);
        end
        check("bit_shape", shape_ok, 1);
        n = 0;
        low_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (led_data) low_ok = 1'b0;
            if (frame_ready) ready_hi++;
        end while (!frame_done && n < 3000);
        check("latch_len", n, 2000);
        check("latch_low", low_ok, 1);
        check("ready_low_in_frame", ready_hi, 0);
        check("busy_at_done", busy, 1);
    endtask

    task automatic idle_checks();
        int act;
        @(negedge clk);
        check("done_pulse_end", frame_done, 0);
        check("idle_ready", frame_ready, 1);
        check("idle_busy", busy, 0);
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (led_data || busy || !frame_ready) act++;
        end
        check("no_extra_frame", act, 0);
    endtask

    initial begin
        int lat, h0, h1, h23, n;
        bit rdy1;
        for (int i = 0; i < 4; i++) mem[i] = 24'd0;

        add_vec(8'd255, 24'h800001, 24'h123456, 24'hABCDEF, 24'h00FF00,
                        24'h800001, 24'h123456, 24'h00FF00, 24'hABCDEF);
        add_vec(8'd255, 24'hFFFFFF, 24'h000000, 24'h5A5A5A, 24'hC3C3C3,
                        24'hFFFFFF, 24'h000000, 24'hC3C3C3, 24'h5A5A5A);
`ifdef WS2812_BRIGHTNESS_EN
        add_vec(8'd127, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                        24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F);
        add_vec(8'd255, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                        24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        add_vec(8'd0,   24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                        24'h000000, 24'h000000, 24'h000000, 24'h000000);
        add_vec(8'd127, 24'h804020, 24'hFFFFFF, 24'h000000, 24'hFF0080,
                        24'h402010, 24'h7F7F7F, 24'h7F0040, 24'h000000);
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_led", led_data, 0);
        check("rst_busy", busy, 1);
        check("rst_ready", frame_ready, 0);
        check("rst_done", frame_done, 0);
        check("rst_row", pix_row, 0);
        check("rst_col", pix_col, 0);
        rst_n = 1'b1;
        count_init("init_latch_len");

        // Table: one frame per vector; vector 0 also gets a mid-frame frame_valid pulse.
        for (int vi = 0; vi < vq.size(); vi++) begin
            start_frame(vi, 1'b0, lat);
            check("start_latency", lat, 2);
            capture_frame(vi, (vi == 0) ? 1 : 0, h0, h1, h23);
            if (vi == 0) begin
                check("bit0_high", h0, 20);
                check("bit1_high", h1, 10);
                check("bit23_high", h23, 20);
            end
            idle_checks();
        end

        // frame_valid held high: next frame starts on the cycle after frame_done.
        start_frame(1, 1'b1, lat);
        check("hold_start_latency", lat, 2);
        capture_frame(1, 0, h0, h1, h23);
        n = 0;
        rdy1 = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) rdy1 = frame_ready;
        end while (!led_data && n < 20);
        check("b2b_ready_after_done", rdy1, 1);
        check("b2b_restart_latency", n, 3);
        capture_frame(1, 2, h0, h1, h23);
        idle_checks();

        // Reset during pixel 1 while led_data is high.
        start_frame(0, 1'b0, lat);
        repeat (24 * 31 + 1) @(negedge clk);
        n = 0;
        while (!led_data && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pix1_led_high_before_rst", led_data, 1);
        check("pix1_col_before_rst", pix_col, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_led", led_data, 0);
        check("midrst_busy", busy, 1);
        check("midrst_ready", frame_ready, 0);
        check("midrst_col", pix_col, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_init("midrst_latch_len");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
